// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with valid/ready handshakes and an iterative 1-bit/cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4,
    parameter int SWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AWIDTH-1:0] aluop,
    input  logic [DWIDTH-1:0] op_a,
    input  logic [DWIDTH-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] result,
    output logic              zero,
    output logic              busy
);
    // Codes follow the controller's {funct7[5], funct3} encoding.
    localparam logic [AWIDTH-1:0] ALUADD  = AWIDTH'(0);
    localparam logic [AWIDTH-1:0] ALUSLL  = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] ALUSLT  = AWIDTH'(2);
    localparam logic [AWIDTH-1:0] ALUSLTU = AWIDTH'(3);
    localparam logic [AWIDTH-1:0] ALUXOR  = AWIDTH'(4);
    localparam logic [AWIDTH-1:0] ALUSRL  = AWIDTH'(5);
    localparam logic [AWIDTH-1:0] ALUOR   = AWIDTH'(6);
    localparam logic [AWIDTH-1:0] ALUAND  = AWIDTH'(7);
    localparam logic [AWIDTH-1:0] ALUSUB  = AWIDTH'(8);
    localparam logic [AWIDTH-1:0] ALUSRA  = AWIDTH'(13);

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] res_q, res_d, alu_res;
    logic              zero_q, zero_d, load, accept;
    logic [SWIDTH-1:0] shamt;

    assign shamt     = op_b[SWIDTH-1:0];
    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign zero      = zero_q;

    always_comb begin
        alu_res = op_a + op_b;
        case (aluop)
            ALUSUB:  alu_res = op_a - op_b;
            ALUSLT:  alu_res = DWIDTH'($signed(op_a) < $signed(op_b));
            ALUSLTU: alu_res = DWIDTH'(op_a < op_b);
            ALUXOR:  alu_res = op_a ^ op_b;
            ALUOR:   alu_res = op_a | op_b;
            ALUAND:  alu_res = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
            ALUSLL:  alu_res = op_a << shamt;
            ALUSRL:  alu_res = op_a >> shamt;
            ALUSRA:  alu_res = DWIDTH'($signed(op_a) >>> shamt);
`else
            ALUSLL, ALUSRL, ALUSRA: alu_res = op_a;
`endif
            default: alu_res = op_a + op_b;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign busy = 1'b0;

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        load    = 1'b0;
        if (accept) begin
            load    = 1'b1;
            res_d   = alu_res;
            state_d = DONE;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
        zero_d = load ? (res_d == '0) : zero_q;
    end
`else
    logic [SWIDTH-1:0] cnt_q, cnt_d;
    logic [AWIDTH-1:0] sop_q, sop_d;
    logic [DWIDTH-1:0] step;
    logic              is_shift;

    assign busy     = (state_q == SHIFT);
    assign is_shift = (aluop == ALUSLL) || (aluop == ALUSRL) || (aluop == ALUSRA);
    // res_q doubles as the shift working register; out_valid is low meanwhile.
    assign step     = (sop_q == ALUSLL) ? {res_q[DWIDTH-2:0], 1'b0}
                                        : {(sop_q == ALUSRA) && res_q[DWIDTH-1], res_q[DWIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sop_d   = sop_q;
        load    = 1'b0;
        if (accept) begin
            load    = 1'b1;
            res_d   = alu_res;
            state_d = DONE;
            if (is_shift && shamt != '0) begin
                state_d = SHIFT;
                cnt_d   = shamt;
                sop_d   = aluop;
            end
        end else if (state_q == SHIFT) begin
            load    = 1'b1;
            res_d   = step;
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == SWIDTH'(1)) ? DONE : SHIFT;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
        zero_d = load ? (res_d == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sop_q <= ALUADD;
        end else begin
            cnt_q <= cnt_d;
            sop_q <= sop_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec (default iterative-shift build).
module tb_alu_exec;
    localparam logic [3:0] ADD = 4'd0, SLL = 4'd1, SLT = 4'd2, SLTU = 4'd3, XOR = 4'd4;
    localparam logic [3:0] SRL = 4'd5, OR = 4'd6, AND = 4'd7, SUB = 4'd8, SRA = 4'd13;

    typedef struct {
        logic [31:0] r;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [3:0]  aluop;
    logic [31:0] op_a, op_b, result;
    exp_t        expq[$];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            SUB:     return a - b;
            SLL:     return a << sh;
            SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU:    return (a < b) ? 32'd1 : 32'd0;
            XOR:     return a ^ b;
            SRL:     return a >> sh;
            SRA:     return $signed(a) >>> sh;
            OR:      return a | b;
            AND:     return a & b;
            default: return a + b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.r = ref_alu(op, a, b);
        e.z = (e.r == 32'd0);
        expq.push_back(e);
    endtask

    // Monitor: every cycle a result is presented it must match the oldest outstanding op.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got %h expected no output", result);
            end else begin
                check("sb_result", result, expq[0].r);
                check("sb_zero", {31'd0, zero}, {31'd0, expq[0].z});
                if (out_ready) void'(expq.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        aluop = op;
        op_a = a;
        op_b = b;
        @(negedge clk);
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        if (in_ready) push_exp(op, a, b);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input int exp_busy, input logic [31:0] exp_res);
        int n, bc;
        out_ready = 1'b1;
        issue(op, a, b);
        n = 1;
        bc = 0;
        while (!out_valid && n < 100) begin
            bc += busy;
            @(posedge clk);
            #1 n++;
        end
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
        check({name, "_result"}, result, exp_res);
        check({name, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [3:0] op;
        logic [31:0] a, b;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        aluop = 4'd0;
        op_a = 32'd0;
        op_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a long shift
        out_ready = 1'b1;
        issue(SLL, 32'd1, 32'd20);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        expq.delete();
        @(negedge clk) rst_n = 1'b1;
        #1 check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // ADD/SUB back-to-back
        out_ready = 1'b1;
        issue(ADD, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap_valid", {31'd0, out_valid}, 32'd1);
        check("add_wrap_result", result, 32'd0);
        check("add_wrap_zero", {31'd0, zero}, 32'd1);
        issue(SUB, 32'd5, 32'd7);
        check("sub_valid", {31'd0, out_valid}, 32'd1);
        check("sub_result", result, 32'hFFFF_FFFE);
        check("sub_zero", {31'd0, zero}, 32'd0);
        @(posedge clk);
        #1;

        run_op("sra4", SRA, 32'h8000_0000, 32'd4, 5, 4, 32'hF800_0000);
        run_op("srl4", SRL, 32'h8000_0000, 32'd4, 5, 4, 32'h0800_0000);
        run_op("sll0", SLL, 32'h0000_1234, 32'h20, 1, 0, 32'h0000_1234);
        run_op("sll31", SLL, 32'h0000_0003, 32'd31, 32, 31, 32'h8000_0000);
        run_op("slt", SLT, 32'hFFFF_FFFF, 32'd1, 1, 0, 32'd1);
        run_op("sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 1, 0, 32'd0);
        run_op("undef_op", 4'd15, 32'd40, 32'd2, 1, 0, 32'd42);

        // Backpressure then same-edge drain + accept
        out_ready = 1'b0;
        issue(XOR, 32'h0000_F0F0, 32'h0000_0FF0);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_result", result, 32'h0000_FF00);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(AND, 32'h0000_FF0F, 32'h0000_0F0F);
        check("b2b_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_result", result, 32'h0000_0F0F);
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'd0;
                1: b = a;
                2: a = 32'hFFFF_FFFF;
                default: ;
            endcase
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            aluop = op;
            op_a = a;
            op_b = b;
            @(negedge clk);
            if (in_valid && in_ready) push_exp(op, a, b);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check("drain_left", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
